// File: rtl/reg_file_2r1w_bypass_pkg.sv
// Shared constants and helpers for the 2-read/1-write register file.
package reg_file_2r1w_bypass_pkg;

   localparam int LANE_W = 8;

   function automatic int lanes(input int n);
      return n / LANE_W;
   endfunction

endpackage

// File: rtl/reg_file_2r1w_bypass_if.sv
// Write port, two read ports and the valid map of the register file as one bundle.
interface reg_file_2r1w_bypass_if
   import reg_file_2r1w_bypass_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 2
);
   localparam int L = lanes(N);
   localparam int D = 1 << W;

   logic           wr_en;
   logic [W-1:0]   w_addr;
   logic [N-1:0]   w_data;
   logic [L-1:0]   w_be;
   logic           ra_en;
   logic           rb_en;
   logic [W-1:0]   ra_addr;
   logic [W-1:0]   rb_addr;
   logic [N-1:0]   ra_data;
   logic [N-1:0]   rb_data;
   logic           ra_valid;
   logic           rb_valid;
   logic [D-1:0]   valid_map;

   modport master (
      output wr_en, w_addr, w_data, w_be,
      output ra_en, rb_en, ra_addr, rb_addr,
      input  ra_data, rb_data, ra_valid, rb_valid, valid_map
   );

   modport slave (
      input  wr_en, w_addr, w_data, w_be,
      input  ra_en, rb_en, ra_addr, rb_addr,
      output ra_data, rb_data, ra_valid, rb_valid, valid_map
   );

endinterface

// File: rtl/reg_file_2r1w_bypass_rf_read_port.sv
// One read port: optional same-cycle write forwarding, then an optional output register.
module rf_read_port
   import reg_file_2r1w_bypass_pkg::*;
#(
   parameter int N      = 8,
   parameter int W      = 2,
   parameter int RD_REG = 1,
   parameter int BYPASS = 1,
   localparam int L     = lanes(N),
   localparam int D     = 1 << W
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic [W-1:0]        addr,
   input  logic [D-1:0][N-1:0] mem,
   input  logic [D-1:0]        valid_map,
   input  logic                wr_en,
   input  logic [W-1:0]        w_addr,
   input  logic [N-1:0]        w_data,
   input  logic [L-1:0]        w_be,
   output logic [N-1:0]        data,
   output logic                valid
);

   logic [N-1:0] stored;
   logic [N-1:0] fwd_data;
   logic         fwd_valid;
   logic         hit;

   assign stored = mem[addr];
   // clr suppresses forwarding: the write it accompanies never lands
   assign hit    = (BYPASS != 0) && wr_en && !clr && (w_addr == addr);

   for (genvar k = 0; k < L; k++) begin : g_lane
      assign fwd_data[k*LANE_W +: LANE_W] = (hit && w_be[k]) ? w_data[k*LANE_W +: LANE_W]
                                                              : stored[k*LANE_W +: LANE_W];
   end

   assign fwd_valid = valid_map[addr] | (hit & (|w_be));

   if (RD_REG != 0) begin : g_reg
      always_ff @(posedge clk) begin
         if (clr) begin
            data  <= '0;
            valid <= 1'b0;
         end else if (en) begin
            data  <= fwd_data;
            valid <= fwd_valid;
         end
      end
   end else begin : g_comb
      logic unused_rd;
      assign unused_rd = ^{clk, en};
      assign data      = fwd_data;
      assign valid     = fwd_valid;
   end

endmodule

// File: rtl/reg_file_2r1w_bypass.sv
// 2**W x N register file: byte-enabled write port, two forwarding read ports, per-entry valid flags.
module reg_file_2r1w_bypass
   import reg_file_2r1w_bypass_pkg::*;
#(
   parameter int N      = 8,
   parameter int W      = 2,
   parameter int RD_REG = 1,
   parameter int BYPASS = 1
) (
   input  logic               clk,
   input  logic               clr,
   reg_file_2r1w_bypass_if.slave bus
);

   localparam int L = lanes(N);
   localparam int D = 1 << W;

   logic [D-1:0][N-1:0] mem;
   logic [D-1:0]        valid_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         mem     <= '0;
         valid_q <= '0;
      end else if (bus.wr_en) begin
         for (int k = 0; k < L; k++) begin
            if (bus.w_be[k])
               mem[bus.w_addr][k*LANE_W +: LANE_W] <= bus.w_data[k*LANE_W +: LANE_W];
         end
         // an all-lanes-off write must not mark the entry live
         if (|bus.w_be)
            valid_q[bus.w_addr] <= 1'b1;
      end
   end

   assign bus.valid_map = valid_q;

   logic [1:0]          rd_en;
   logic [1:0][W-1:0]   rd_addr;
   logic [1:0][N-1:0]   rd_data;
   logic [1:0]          rd_valid;

   assign rd_en   = {bus.rb_en, bus.ra_en};
   assign rd_addr = {bus.rb_addr, bus.ra_addr};

   for (genvar p = 0; p < 2; p++) begin : g_port
      rf_read_port #(
         .N      (N),
         .W      (W),
         .RD_REG (RD_REG),
         .BYPASS (BYPASS)
      ) u_rd (
         .clk       (clk),
         .clr       (clr),
         .en        (rd_en[p]),
         .addr      (rd_addr[p]),
         .mem       (mem),
         .valid_map (valid_q),
         .wr_en     (bus.wr_en),
         .w_addr    (bus.w_addr),
         .w_data    (bus.w_data),
         .w_be      (bus.w_be),
         .data      (rd_data[p]),
         .valid     (rd_valid[p])
      );
   end

   assign bus.ra_data  = rd_data[0];
   assign bus.rb_data  = rd_data[1];
   assign bus.ra_valid = rd_valid[0];
   assign bus.rb_valid = rd_valid[1];

endmodule

// File: tb/tb_reg_file_2r1w_bypass.sv
// Directed vectors for the register file: registered read with and without bypass (8 bit),
// plus a combinational-read 32-bit instance for byte enables and mid-operation reset.
module tb_reg_file_2r1w_bypass;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr0;
   logic clr2;

   reg_file_2r1w_bypass_if #(.N(8),  .W(2)) if0();
   reg_file_2r1w_bypass_if #(.N(8),  .W(2)) if1();
   reg_file_2r1w_bypass_if #(.N(32), .W(2)) if2();

   // u1 sees exactly the stimulus of u0, only BYPASS differs
   assign if1.wr_en   = if0.wr_en;
   assign if1.w_addr  = if0.w_addr;
   assign if1.w_data  = if0.w_data;
   assign if1.w_be    = if0.w_be;
   assign if1.ra_en   = if0.ra_en;
   assign if1.rb_en   = if0.rb_en;
   assign if1.ra_addr = if0.ra_addr;
   assign if1.rb_addr = if0.rb_addr;

   reg_file_2r1w_bypass #(.N(8),  .W(2), .RD_REG(1), .BYPASS(1)) u0 (.clk(clk), .clr(clr0), .bus(if0));
   reg_file_2r1w_bypass #(.N(8),  .W(2), .RD_REG(1), .BYPASS(0)) u1 (.clk(clk), .clr(clr0), .bus(if1));
   reg_file_2r1w_bypass #(.N(32), .W(2), .RD_REG(0), .BYPASS(1)) u2 (.clk(clk), .clr(clr2), .bus(if2));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic       clr;
      logic       we;
      logic [1:0] wa;
      logic [7:0] wd;
      logic       be;
      logic       rae;
      logic [1:0] raa;
      logic       rbe;
      logic [1:0] rba;
      logic [7:0] ea;    // u0 expectations after the edge
      logic       eav;
      logic [7:0] eb;
      logic       ebv;
      logic [3:0] emap;
      logic [7:0] ea0;   // u1 (no bypass) port A expectations
      logic       eav0;
   } vec_t;

   vec_t tv[20];

   initial begin
      //          clr we wa wd     be rae raa rbe rba ea     eav eb     ebv emap  ea0    eav0
      tv[0]  = '{1, 1, 0, 8'hFF, 1, 1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0};
      tv[1]  = '{0, 1, 0, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4'h1, 8'h00, 0};
      tv[2]  = '{0, 1, 1, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4'h3, 8'h00, 0};
      tv[3]  = '{0, 1, 2, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4'h7, 8'h00, 0};
      tv[4]  = '{0, 1, 3, 8'hA5, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4'hF, 8'h00, 0};
      tv[5]  = '{1, 0, 0, 8'h00, 0, 1, 2, 1, 3, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0};
      tv[6]  = '{0, 0, 0, 8'h00, 0, 1, 0, 1, 1, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0};
      tv[7]  = '{0, 0, 0, 8'h00, 0, 1, 2, 1, 3, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0};
      tv[8]  = '{0, 1, 1, 8'h5C, 1, 1, 1, 1, 0, 8'h5C, 1, 8'h00, 0, 4'h2, 8'h00, 0};
      tv[9]  = '{0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 8'h5C, 1, 8'h00, 0, 4'h2, 8'h5C, 1};
      tv[10] = '{0, 1, 3, 8'h7E, 1, 1, 3, 1, 3, 8'h7E, 1, 8'h7E, 1, 4'hA, 8'h00, 0};
      tv[11] = '{0, 0, 0, 8'h00, 0, 1, 0, 1, 3, 8'h00, 0, 8'h7E, 1, 4'hA, 8'h00, 0};
      tv[12] = '{0, 1, 2, 8'h42, 1, 1, 2, 0, 0, 8'h42, 1, 8'h7E, 1, 4'hE, 8'h00, 0};
      tv[13] = '{0, 0, 0, 8'h00, 0, 1, 2, 0, 0, 8'h42, 1, 8'h7E, 1, 4'hE, 8'h42, 1};
      tv[14] = '{0, 1, 2, 8'h99, 1, 0, 2, 0, 0, 8'h42, 1, 8'h7E, 1, 4'hE, 8'h42, 1};
      tv[15] = '{0, 0, 0, 8'h00, 0, 0, 2, 0, 0, 8'h42, 1, 8'h7E, 1, 4'hE, 8'h42, 1};
      tv[16] = '{0, 0, 0, 8'h00, 0, 1, 2, 0, 0, 8'h99, 1, 8'h7E, 1, 4'hE, 8'h99, 1};
      tv[17] = '{0, 1, 0, 8'h33, 0, 1, 0, 0, 0, 8'h00, 0, 8'h7E, 1, 4'hE, 8'h00, 0};
      tv[18] = '{1, 1, 0, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0};
      tv[19] = '{0, 0, 0, 8'h00, 0, 1, 0, 1, 2, 8'h00, 0, 8'h00, 0, 4'h0, 8'h00, 0};

      clr2        = 1'b1;
      if2.wr_en   = 1'b0;
      if2.w_addr  = '0;
      if2.w_data  = '0;
      if2.w_be    = '0;
      if2.ra_en   = 1'b0;
      if2.rb_en   = 1'b0;
      if2.ra_addr = '0;
      if2.rb_addr = '0;

      // registered-read instances, one vector per clock
      for (int i = 0; i < 20; i++) begin
         clr0        = tv[i].clr;
         if0.wr_en   = tv[i].we;
         if0.w_addr  = tv[i].wa;
         if0.w_data  = tv[i].wd;
         if0.w_be    = tv[i].be;
         if0.ra_en   = tv[i].rae;
         if0.ra_addr = tv[i].raa;
         if0.rb_en   = tv[i].rbe;
         if0.rb_addr = tv[i].rba;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d u0.ra_data", i),   32'(if0.ra_data),   32'(tv[i].ea));
         chk($sformatf("v%0d u0.ra_valid", i),  32'(if0.ra_valid),  32'(tv[i].eav));
         chk($sformatf("v%0d u0.rb_data", i),   32'(if0.rb_data),   32'(tv[i].eb));
         chk($sformatf("v%0d u0.rb_valid", i),  32'(if0.rb_valid),  32'(tv[i].ebv));
         chk($sformatf("v%0d u0.valid_map", i), 32'(if0.valid_map), 32'(tv[i].emap));
         chk($sformatf("v%0d u1.ra_data", i),   32'(if1.ra_data),   32'(tv[i].ea0));
         chk($sformatf("v%0d u1.ra_valid", i),  32'(if1.ra_valid),  32'(tv[i].eav0));
         chk($sformatf("v%0d u1.valid_map", i), 32'(if1.valid_map), 32'(tv[i].emap));
      end
      clr0      = 1'b0;
      if0.wr_en = 1'b0;

      // 32-bit combinational read: reset, byte enables, forwarding, mid-op reset
      @(posedge clk); #1;
      clr2 = 1'b0;
      #1;
      chk("w32 reset map",      32'(if2.valid_map), 32'h0);
      chk("w32 reset ra_data",  if2.ra_data,        32'h0);
      chk("w32 reset ra_valid", 32'(if2.ra_valid),  32'h0);

      if2.wr_en = 1'b1; if2.w_addr = 2; if2.w_data = 32'h11223344; if2.w_be = 4'hF;
      if2.ra_addr = 2; if2.rb_addr = 1;
      #1;
      chk("w32 fwd full ra_data",  if2.ra_data,        32'h11223344);
      chk("w32 fwd full ra_valid", 32'(if2.ra_valid),  32'h1);
      chk("w32 fwd miss rb_data",  if2.rb_data,        32'h0);
      chk("w32 fwd miss rb_valid", 32'(if2.rb_valid),  32'h0);
      chk("w32 map not forwarded", 32'(if2.valid_map), 32'h0);
      @(posedge clk); #1;
      if2.wr_en = 1'b0;
      #1;
      chk("w32 full ra_data",  if2.ra_data,        32'h11223344);
      chk("w32 full ra_valid", 32'(if2.ra_valid),  32'h1);
      chk("w32 full map",      32'(if2.valid_map), 32'h4);

      if2.wr_en = 1'b1; if2.w_data = 32'hAABBCCDD; if2.w_be = 4'b0101;
      #1;
      chk("w32 fwd merge ra_data", if2.ra_data, 32'h11BB33DD);
      @(posedge clk); #1;
      if2.wr_en = 1'b0;
      #1;
      chk("w32 merge ra_data",  if2.ra_data,       32'h11BB33DD);
      chk("w32 merge ra_valid", 32'(if2.ra_valid), 32'h1);

      if2.wr_en = 1'b1; if2.w_addr = 3; if2.w_data = 32'hFFFFFFFF; if2.w_be = 4'h0;
      if2.rb_addr = 3;
      #1;
      chk("w32 be0 fwd rb_data",  if2.rb_data,       32'h0);
      chk("w32 be0 fwd rb_valid", 32'(if2.rb_valid), 32'h0);
      @(posedge clk); #1;
      if2.wr_en = 1'b0;
      #1;
      chk("w32 be0 rb_data",  if2.rb_data,        32'h0);
      chk("w32 be0 rb_valid", 32'(if2.rb_valid),  32'h0);
      chk("w32 be0 map",      32'(if2.valid_map), 32'h4);
      chk("w32 be0 ra_data",  if2.ra_data,        32'h11BB33DD);

      clr2 = 1'b1;
      if2.wr_en = 1'b1; if2.w_addr = 2; if2.w_data = 32'h0; if2.w_be = 4'hF;
      #1;
      chk("w32 clr pre-edge ra_data",  if2.ra_data,       32'h11BB33DD);
      chk("w32 clr pre-edge ra_valid", 32'(if2.ra_valid), 32'h1);
      @(posedge clk); #1;
      clr2 = 1'b0;
      if2.wr_en = 1'b0;
      #1;
      chk("w32 clr post ra_data",  if2.ra_data,        32'h0);
      chk("w32 clr post ra_valid", 32'(if2.ra_valid),  32'h0);
      chk("w32 clr post map",      32'(if2.valid_map), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
